// File: rtl/serial_transmit_word.sv
// 8N1 UART transmitter: sends a 32-bit word as four bytes, low byte first, LSB first.
// Optional SERIAL_TX_TWO_STOP_EN: two stop bits per byte (44 bit periods per word).
module serial_transmit_word #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] word,
    output logic        TxD,
    output logic        busy
);

    localparam int DIV = comm_clk_frequency / baud_rate;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef SERIAL_TX_TWO_STOP_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [3:0]    bit_cnt, bit_n;
    logic [1:0]    byte_cnt, byte_n;
    logic [31:0]   sr, sr_n;
    logic          txd_n, busy_n, load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            TxD      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            sr       <= sr_n;
            TxD      <= txd_n;
            busy     <= busy_n;
        end
    end

    // TxD is computed one cycle ahead so the line value is a flop output.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        sr_n    = sr;
        txd_n   = TxD;
        busy_n  = busy;
        load    = 1'b0;
        case (state)
            IDLE: load = send;
            SHIFT: begin
                if (div_cnt == DW'(DIV - 1)) begin
                    div_n = '0;
                    if (bit_cnt == 4'(FRAME - 1)) begin
                        bit_n = '0;
                        if (byte_cnt == 2'd3) begin
                            // Last stop bit ends; a send on this edge chains the next word.
                            state_n = IDLE;
                            txd_n   = 1'b1;
                            busy_n  = 1'b0;
                            load    = send;
                        end else begin
                            byte_n = byte_cnt + 2'd1;
                            txd_n  = 1'b0;
                        end
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            txd_n = sr[0];
                            sr_n  = {1'b0, sr[31:1]};
                        end else begin
                            txd_n = 1'b1;
                        end
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = SHIFT;
            busy_n  = 1'b1;
            txd_n   = 1'b0;
            sr_n    = word;
            div_n   = '0;
            bit_n   = '0;
            byte_n  = '0;
        end
    end

endmodule

// File: tb/tb_serial_transmit_word.sv
// Bench for serial_transmit_word: table vectors, ignored-send, reset and random streaming
// checked cycle by cycle against a frame-level line model and a mid-bit 8N1 receiver.
module tb_serial_transmit_word;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 115_200;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef SERIAL_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif
    localparam int FRAME    = 9 + STOPS;
    localparam int WORD_CYC = 4 * FRAME * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [31:0] word_in;
    logic        TxD;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [0:0] exp_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] rx_q[$];
    logic [31:0] words_q[$];

    typedef struct {
        logic [31:0] word;
        logic [31:0] bytes;   // {byte3, byte2, byte1, byte0} as sent on the line
    } vec_t;

    vec_t vecs[6];

    serial_transmit_word #(
        .comm_clk_frequency(CLK_HZ),
        .baud_rate(BAUD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send(send),
        .word(word_in),
        .TxD(TxD),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Line model: each byte is start(0), 8 data bits LSB first, STOPS stop bits, DIV cycles each.
    task automatic build_line();
        exp_q.delete();
        foreach (exp_b_q[i]) begin
            for (int p = 0; p < FRAME; p++) begin
                logic v;
                if (p == 0) v = 1'b0;
                else if (p <= 8) v = exp_b_q[i][p-1];
                else v = 1'b1;
                for (int k = 0; k < DIV; k++) exp_q.push_back(v);
            end
        end
    endtask

    // Sends words_q back to back, checking TxD/busy every cycle; poke_at>0 pulses an
    // extra send with 32'hdeadbeef during that cycle of the transfer.
    task automatic run_stream(input int poke_at);
        int n;
        logic [7:0] rx_byte;
        n = words_q.size();
        build_line();
        rx_q.delete();
        rx_byte = '0;
        @(negedge clk);
        send = 1'b1;
        word_in = words_q[0];
        @(posedge clk);
        #1 send = 1'b0;
        word_in = $urandom;
        for (int c = 1; c <= n * WORD_CYC; c++) begin
            int p, f;
            logic [0:0] e;
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("txd_c%0d", c), {31'b0, TxD}, {31'b0, e});
            chk($sformatf("busy_c%0d", c), {31'b0, busy}, 32'd1);
            if ((c - 1) % DIV == DIV / 2) begin
                p = (c - 1) / DIV;
                f = p % FRAME;
                if (f >= 1 && f <= 8) rx_byte[f-1] = TxD;
                if (f == 8) rx_q.push_back(rx_byte);
            end
            send = 1'b0;
            if (c % WORD_CYC == 0 && c / WORD_CYC < n) begin
                send = 1'b1;
                word_in = words_q[c / WORD_CYC];
            end
            if (c == poke_at) begin
                send = 1'b1;
                word_in = 32'hdeadbeef;
            end
        end
        send = 1'b0;
        @(negedge clk);
        chk("end_txd", {31'b0, TxD}, 32'd1);
        chk("end_busy", {31'b0, busy}, 32'd0);
        chk("rx_count", rx_q.size(), exp_b_q.size());
        foreach (exp_b_q[i]) begin
            if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_b_q[i]});
        end
        words_q.delete();
        exp_b_q.delete();
    endtask

    task automatic push_vec(input vec_t v);
        words_q.push_back(v.word);
        for (int b = 0; b < 4; b++) exp_b_q.push_back(v.bytes[8*b +: 8]);
    endtask

    initial begin
        vecs[0] = '{32'h000007ff, {8'h00, 8'h00, 8'h07, 8'hff}};
        vecs[1] = '{32'h0000318e, {8'h00, 8'h00, 8'h31, 8'h8e}};
        vecs[2] = '{32'h55aa07ff, {8'h55, 8'haa, 8'h07, 8'hff}};
        vecs[3] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{32'hffffffff, {8'hff, 8'hff, 8'hff, 8'hff}};
        vecs[5] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};

        send = 1'b0;
        word_in = '0;
        reset = 1'b1;
        #12;
        chk("rst_txd", {31'b0, TxD}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_txd", {31'b0, TxD}, 32'd1);

        // table vectors, one word each
        foreach (vecs[i]) begin
            push_vec(vecs[i]);
            run_stream(0);
        end

        // send pulsed mid-transfer must be ignored
        push_vec(vecs[0]);
        run_stream(100);

        // reset while idle
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_idle_txd", {31'b0, TxD}, 32'd1);
        chk("rst_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset mid-word while the line is low (data zeros of word 0)
        @(negedge clk);
        send = 1'b1;
        word_in = 32'h0;
        @(posedge clk);
        #1 send = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_txd", {31'b0, TxD}, 32'd0);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_txd", {31'b0, TxD}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3 * FRAME * DIV; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_txd_c%0d", c), {31'b0, TxD}, 32'd1);
            chk($sformatf("post_rst_busy_c%0d", c), {31'b0, busy}, 32'd0);
        end

        // 21 random words streamed with no gap (84-byte work unit)
        for (int w = 0; w < 21; w++) begin
            logic [31:0] r;
            r = $urandom;
            words_q.push_back(r);
            for (int b = 0; b < 4; b++) exp_b_q.push_back(8'((r >> (8 * b)) & 32'hff));
        end
        run_stream(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
